// File: rtl/fwrisc_regfile_csr.sv
// GPR bank plus CSR file for the fwrisc core.
// A sequenced clear FSM zeroes the GPRs one per cycle after reset. Both read ports are
// registered, with optional same-cycle forwarding of a committing write.
module fwrisc_regfile_csr #(
  parameter int unsigned NUM_GPR         = 32,
  parameter int unsigned COUNTER_WIDTH   = 64,
  parameter bit          ENABLE_COUNTERS = 1'b1,
  parameter bit          ENABLE_DEP      = 1'b1,
  parameter bit          BYPASS          = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic        ready,
  output logic        soft_reset_req,
  output logic        addr_err,
  input  logic        instr_complete,
  input  logic [5:0]  ra_raddr,
  output logic [31:0] ra_rdata,
  input  logic [5:0]  rb_raddr,
  output logic [31:0] rb_rdata,
  input  logic [5:0]  rd_waddr,
  input  logic [31:0] rd_wdata,
  input  logic        rd_wen,
  output logic [31:0] dep_lo,
  output logic [31:0] dep_hi,
  output logic [31:0] mtvec
);

  localparam int unsigned IdxW       = $clog2(NUM_GPR);
  localparam int unsigned HiW        = COUNTER_WIDTH - 32;
  localparam int unsigned NumScratch = 23;

  localparam logic [5:0] AddrMcycle    = 6'h20;
  localparam logic [5:0] AddrMcycleH   = 6'h21;
  localparam logic [5:0] AddrMinstret  = 6'h22;
  localparam logic [5:0] AddrMinstretH = 6'h23;
  localparam logic [5:0] AddrInhibit   = 6'h24;
  localparam logic [5:0] AddrMtvec     = 6'h25;
  localparam logic [5:0] AddrDepLo     = 6'h26;
  localparam logic [5:0] AddrDepHi     = 6'h27;
  localparam logic [5:0] AddrSoftReset = 6'h28;
  localparam logic [5:0] AddrScratch   = 6'h29;

  localparam logic [COUNTER_WIDTH-1:0] CntOne = COUNTER_WIDTH'(1);

  typedef enum logic [0:0] {StClear, StRun} state_e;

  state_e              state_q, state_d;
  logic [IdxW-1:0]     idx_q, idx_d;

  logic [31:0]              regs_q    [NUM_GPR];
  logic [31:0]              scratch_q [NumScratch];
  logic [31:0]              inhibit_q, mtvec_q, dep_lo_q, dep_hi_q;
  logic [COUNTER_WIDTH-1:0] mcycle_q, mcycle_d, minstret_q, minstret_d;

  logic [31:0] ra_d, rb_d;
  logic        addr_err_d, soft_reset_d;

  // GPR address that exists in this bank
  function automatic logic gpr_ok(logic [5:0] a);
    return (a[5] == 1'b0) && (32'(a) < NUM_GPR);
  endfunction

  // GPR-range address beyond the implemented bank (RV32E upper half)
  function automatic logic gpr_bad(logic [5:0] a);
    return (a[5] == 1'b0) && (32'(a) >= NUM_GPR);
  endfunction

  logic       run;
  logic       wr_any;
  logic [5:0] scr_woff, scr_roff;
  logic       wr_gpr, wr_inhibit, wr_mtvec, wr_dep_lo, wr_dep_hi, wr_scratch, wr_plain;
  logic       wr_mcycle, wr_mcycleh, wr_minstret, wr_minstreth;

  assign run      = (state_q == StRun);
  assign wr_any   = run && rd_wen;
  assign scr_woff = rd_waddr - AddrScratch;
  assign scr_roff = rb_raddr - AddrScratch;

  assign wr_gpr       = wr_any && gpr_ok(rd_waddr) && (rd_waddr != 6'd0);
  assign wr_inhibit   = wr_any && (rd_waddr == AddrInhibit);
  assign wr_mtvec     = wr_any && (rd_waddr == AddrMtvec);
  // Bit1 of each DEP register is a sticky lock: once set, writes are refused until reset
  assign wr_dep_lo    = wr_any && ENABLE_DEP && (rd_waddr == AddrDepLo) && !dep_lo_q[1];
  assign wr_dep_hi    = wr_any && ENABLE_DEP && (rd_waddr == AddrDepHi) && !dep_hi_q[1];
  assign wr_scratch   = wr_any && (rd_waddr >= AddrScratch);
  assign wr_mcycle    = wr_any && (rd_waddr == AddrMcycle);
  assign wr_mcycleh   = wr_any && (rd_waddr == AddrMcycleH);
  assign wr_minstret  = wr_any && (rd_waddr == AddrMinstret);
  assign wr_minstreth = wr_any && (rd_waddr == AddrMinstretH);

  // Writes that land in plain storage and are therefore eligible for forwarding
  assign wr_plain = wr_gpr | wr_inhibit | wr_mtvec | wr_dep_lo | wr_dep_hi | wr_scratch;

  assign ready  = run;
  assign dep_lo = dep_lo_q;
  assign dep_hi = dep_hi_q;
  assign mtvec  = mtvec_q;

  // Clear sequencer next state: walk idx across the bank, then enter RUN
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      StClear: begin
        idx_d = idx_q + IdxW'(1);
        if (idx_q == IdxW'(NUM_GPR - 1)) begin
          state_d = StRun;
          idx_d   = '0;
        end
      end
      StRun:   state_d = StRun;
      default: state_d = StClear;
    endcase
  end

  // Clear sequencer state register
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= StClear;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // GPR storage: cleared by the sequencer, otherwise written from writeback
  always_ff @(posedge clock) begin
    if (reset_n) begin
      if (state_q == StClear) begin
        regs_q[idx_q] <= '0;
      end else if (wr_gpr) begin
        regs_q[rd_waddr[IdxW-1:0]] <= rd_wdata;
      end
    end
  end

  // Counter next state: an explicit write to either half wins over the increment
  always_comb begin
    mcycle_d   = mcycle_q;
    minstret_d = minstret_q;
    if (!ENABLE_COUNTERS) begin
      mcycle_d   = '0;
      minstret_d = '0;
    end else begin
      if (wr_mcycle) begin
        mcycle_d[31:0] = rd_wdata;
      end else if (wr_mcycleh) begin
        mcycle_d[COUNTER_WIDTH-1:32] = rd_wdata[HiW-1:0];
      end else if (!inhibit_q[0]) begin
        mcycle_d = mcycle_q + CntOne;
      end
      if (wr_minstret) begin
        minstret_d[31:0] = rd_wdata;
      end else if (wr_minstreth) begin
        minstret_d[COUNTER_WIDTH-1:32] = rd_wdata[HiW-1:0];
      end else if (instr_complete && !inhibit_q[2]) begin
        minstret_d = minstret_q + CntOne;
      end
    end
  end

  // CSR storage and counters
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      inhibit_q  <= '0;
      mtvec_q    <= '0;
      dep_lo_q   <= '0;
      dep_hi_q   <= '0;
      mcycle_q   <= '0;
      minstret_q <= '0;
      for (int i = 0; i < NumScratch; i++) begin
        scratch_q[i] <= '0;
      end
    end else begin
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
      if (wr_inhibit) inhibit_q <= rd_wdata;
      if (wr_mtvec)   mtvec_q   <= rd_wdata;
      if (wr_dep_lo)  dep_lo_q  <= rd_wdata;
      if (wr_dep_hi)  dep_hi_q  <= rd_wdata;
      if (wr_scratch) scratch_q[scr_woff[4:0]] <= rd_wdata;
    end
  end

  // Read mux and forwarding; counters deliberately return their pre-write value
  always_comb begin
    ra_d = '0;
    rb_d = '0;
    if (run) begin
      if (gpr_ok(ra_raddr) && (ra_raddr != 6'd0)) begin
        ra_d = regs_q[ra_raddr[IdxW-1:0]];
      end
      if (rb_raddr[5] == 1'b0) begin
        if (gpr_ok(rb_raddr) && (rb_raddr != 6'd0)) begin
          rb_d = regs_q[rb_raddr[IdxW-1:0]];
        end
      end else begin
        case (rb_raddr)
          AddrMcycle:    rb_d = mcycle_q[31:0];
          AddrMcycleH:   rb_d = 32'(mcycle_q[COUNTER_WIDTH-1:32]);
          AddrMinstret:  rb_d = minstret_q[31:0];
          AddrMinstretH: rb_d = 32'(minstret_q[COUNTER_WIDTH-1:32]);
          AddrInhibit:   rb_d = inhibit_q;
          AddrMtvec:     rb_d = mtvec_q;
          AddrDepLo:     rb_d = dep_lo_q;
          AddrDepHi:     rb_d = dep_hi_q;
          AddrSoftReset: rb_d = '0;
          default:       rb_d = scratch_q[scr_roff[4:0]];
        endcase
      end
      if (BYPASS && wr_gpr && (rd_waddr == ra_raddr)) ra_d = rd_wdata;
      if (BYPASS && wr_plain && (rd_waddr == rb_raddr)) rb_d = rd_wdata;
    end
  end

  assign addr_err_d   = run && (gpr_bad(ra_raddr) || gpr_bad(rb_raddr) ||
                                (rd_wen && gpr_bad(rd_waddr)));
  assign soft_reset_d = wr_any && (rd_waddr == AddrSoftReset);

  // Registered read data and status pulses
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      ra_rdata       <= '0;
      rb_rdata       <= '0;
      addr_err       <= 1'b0;
      soft_reset_req <= 1'b0;
    end else begin
      ra_rdata       <= ra_d;
      rb_rdata       <= rb_d;
      addr_err       <= addr_err_d;
      soft_reset_req <= soft_reset_d;
    end
  end

endmodule

// File: tb/tb_fwrisc_regfile_csr.sv
// Bench for fwrisc_regfile_csr: an RV32I instance (a_*) and an RV32E instance (e_*) share
// one stimulus stream. Directed scenarios check fixed values; the random scenario checks
// both instances against a behavioural model of the register file.
module tb_fwrisc_regfile_csr;

  logic        clock;
  logic        reset_n;
  logic        instr_complete;
  logic [5:0]  ra_raddr, rb_raddr, rd_waddr;
  logic [31:0] rd_wdata;
  logic        rd_wen;

  logic        a_ready, a_srr, a_err, e_ready, e_srr, e_err;
  logic [31:0] a_ra, a_rb, a_dlo, a_dhi, a_mtvec;
  logic [31:0] e_ra, e_rb, e_dlo, e_dhi, e_mtvec;

  int n_cmp = 0;
  int n_bad = 0;

  fwrisc_regfile_csr #(.NUM_GPR(32)) u_dut_i (
    .clock(clock), .reset_n(reset_n), .ready(a_ready), .soft_reset_req(a_srr),
    .addr_err(a_err), .instr_complete(instr_complete), .ra_raddr(ra_raddr),
    .ra_rdata(a_ra), .rb_raddr(rb_raddr), .rb_rdata(a_rb), .rd_waddr(rd_waddr),
    .rd_wdata(rd_wdata), .rd_wen(rd_wen), .dep_lo(a_dlo), .dep_hi(a_dhi), .mtvec(a_mtvec)
  );

  fwrisc_regfile_csr #(.NUM_GPR(16)) u_dut_e (
    .clock(clock), .reset_n(reset_n), .ready(e_ready), .soft_reset_req(e_srr),
    .addr_err(e_err), .instr_complete(instr_complete), .ra_raddr(ra_raddr),
    .ra_rdata(e_ra), .rb_raddr(rb_raddr), .rb_rdata(e_rb), .rd_waddr(rd_waddr),
    .rd_wdata(rd_wdata), .rd_wen(rd_wen), .dep_lo(e_dlo), .dep_hi(e_dhi), .mtvec(e_mtvec)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural model state, index 0 = RV32I, 1 = RV32E
  logic [31:0] m_gpr [2][32];
  logic [31:0] m_csr [2][64];
  logic [63:0] m_cyc [2];
  logic [63:0] m_ins [2];
  bit          m_clear [2];
  int          m_clr_n [2];
  logic [31:0] x_ra [2];
  logic [31:0] x_rb [2];
  bit          x_err [2];
  bit          x_srr [2];

  function automatic int num(int k);
    return (k == 0) ? 32 : 16;
  endfunction

  function automatic bit illegal(int k, logic [5:0] a);
    return (a < 6'd32) && (int'(a) >= num(k));
  endfunction

  // True when a write to a lands in plain storage (not a counter, not write-only, not locked)
  function automatic bit stored_write(int k, logic [5:0] a);
    if (a < 6'd32) return (a != 6'd0) && (int'(a) < num(k));
    if (a >= 6'h20 && a <= 6'h23) return 1'b0;
    if (a == 6'h28) return 1'b0;
    if (a == 6'h26 || a == 6'h27) return (m_csr[k][a][1] == 1'b0);
    return 1'b1;
  endfunction

  function automatic logic [31:0] peek(int k, logic [5:0] a, bit portb);
    if (a < 6'd32) return (a == 6'd0 || int'(a) >= num(k)) ? 32'd0 : m_gpr[k][a[4:0]];
    if (!portb) return 32'd0;
    case (a)
      6'h20:   return m_cyc[k][31:0];
      6'h21:   return m_cyc[k][63:32];
      6'h22:   return m_ins[k][31:0];
      6'h23:   return m_ins[k][63:32];
      6'h28:   return 32'd0;
      default: return m_csr[k][a];
    endcase
  endfunction

  // Advance the model by one clock using the inputs currently driven
  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      if (!reset_n) begin
        for (int i = 0; i < 32; i++) m_gpr[k][i] = 32'd0;
        for (int i = 0; i < 64; i++) m_csr[k][i] = 32'd0;
        m_cyc[k] = 64'd0;  m_ins[k] = 64'd0;
        m_clear[k] = 1'b1; m_clr_n[k] = 0;
        x_ra[k] = 32'd0;   x_rb[k] = 32'd0;
        x_err[k] = 1'b0;   x_srr[k] = 1'b0;
      end else begin
        bit          run;
        bit          commit;
        logic [31:0] inh;
        run    = !m_clear[k];
        inh    = m_csr[k][6'h24];
        commit = run && rd_wen && stored_write(k, rd_waddr);
        x_ra[k] = !run ? 32'd0 :
                  (commit && ra_raddr == rd_waddr && ra_raddr < 6'd32) ? rd_wdata :
                  peek(k, ra_raddr, 1'b0);
        x_rb[k] = !run ? 32'd0 :
                  (commit && rb_raddr == rd_waddr) ? rd_wdata : peek(k, rb_raddr, 1'b1);
        x_err[k] = run && (illegal(k, ra_raddr) || illegal(k, rb_raddr) ||
                           (rd_wen && illegal(k, rd_waddr)));
        x_srr[k] = run && rd_wen && (rd_waddr == 6'h28);
        if (run && rd_wen && rd_waddr == 6'h20)      m_cyc[k][31:0]  = rd_wdata;
        else if (run && rd_wen && rd_waddr == 6'h21) m_cyc[k][63:32] = rd_wdata;
        else if (!inh[0])                            m_cyc[k] = m_cyc[k] + 64'd1;
        if (run && rd_wen && rd_waddr == 6'h22)      m_ins[k][31:0]  = rd_wdata;
        else if (run && rd_wen && rd_waddr == 6'h23) m_ins[k][63:32] = rd_wdata;
        else if (instr_complete && !inh[2])          m_ins[k] = m_ins[k] + 64'd1;
        if (commit) begin
          if (rd_waddr < 6'd32) m_gpr[k][rd_waddr[4:0]] = rd_wdata;
          else                  m_csr[k][rd_waddr]      = rd_wdata;
        end
        if (m_clear[k]) begin
          m_clr_n[k]++;
          if (m_clr_n[k] == num(k)) m_clear[k] = 1'b0;
        end
      end
    end
  endtask

  // One clock: the model consumes the driven inputs, then we move to the sampling edge
  task automatic cycle();
    model_step();
    @(negedge clock);
  endtask

  task automatic drive(bit wen, logic [5:0] wa, logic [31:0] wd, logic [5:0] ra,
                       logic [5:0] rb);
    rd_wen = wen; rd_waddr = wa; rd_wdata = wd; ra_raddr = ra; rb_raddr = rb;
  endtask

  task automatic wait_ready(string tag);
    int ta, te;
    ta = 0; te = 0;
    for (int t = 1; t <= 40; t++) begin
      cycle();
      if (a_ready && ta == 0) ta = t;
      if (e_ready && te == 0) te = t;
    end
    n_cmp++;
    if (ta != 32) begin n_bad++; $display("FAIL %s_ready32: rose after %0d want 32", tag, ta); end
    n_cmp++;
    if (te != 16) begin n_bad++; $display("FAIL %s_ready16: rose after %0d want 16", tag, te); end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; instr_complete = 1'b0;
    drive(1'b1, 6'd3, 32'h1234, 6'd3, 6'd3);
    repeat (3) cycle();
    n_cmp++;
    if ({a_ready, e_ready, a_err, a_srr} !== 4'b0) begin
      n_bad++; $display("FAIL reset_flags: got %b want 0000", {a_ready, e_ready, a_err, a_srr});
    end
    n_cmp++;
    if ({a_ra, a_rb, a_dlo, a_dhi, a_mtvec} !== 160'd0) begin
      n_bad++; $display("FAIL reset_regs: ra=%h rb=%h dlo=%h dhi=%h mtvec=%h want 0",
                        a_ra, a_rb, a_dlo, a_dhi, a_mtvec);
    end
    drive(1'b0, 6'd0, 32'd0, 6'd0, 6'd0);
    reset_n = 1'b1;
    wait_ready("t1_first");
    for (int i = 1; i < 32; i++) begin
      drive(1'b1, 6'(i), 32'h100 + i, 6'd0, 6'd0);
      cycle();
    end
    drive(1'b0, 6'd0, 32'd0, 6'd0, 6'd0);
    reset_n = 1'b0; cycle();
    reset_n = 1'b1; repeat (5) cycle();
    reset_n = 1'b0; cycle();
    reset_n = 1'b1;
    wait_ready("t1_restart");
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 6'd0, 32'd0, 6'(i), 6'(31 - i));
      cycle();
      n_cmp++;
      if (a_ra !== 32'd0 || a_rb !== 32'd0) begin
        n_bad++; $display("FAIL t1_cleared x%0d: ra=%h rb=%h want 0", i, a_ra, a_rb);
      end
    end
  endtask

  task automatic test_bypass();
    drive(1'b1, 6'd5, 32'hDEADBEEF, 6'd5, 6'd0); cycle();
    n_cmp++;
    if (a_ra !== 32'hDEADBEEF) begin n_bad++; $display("FAIL t2_bypass: ra=%h want deadbeef", a_ra); end
    drive(1'b0, 6'd0, 32'd0, 6'd5, 6'd0); cycle();
    n_cmp++;
    if (a_ra !== 32'hDEADBEEF) begin n_bad++; $display("FAIL t2_stored: ra=%h want deadbeef", a_ra); end
    drive(1'b1, 6'd0, 32'h1, 6'd0, 6'd0); cycle();
    n_cmp++;
    if (a_ra !== 32'd0 || a_rb !== 32'd0) begin
      n_bad++; $display("FAIL t2_x0_bypass: ra=%h rb=%h want 0", a_ra, a_rb);
    end
    drive(1'b0, 6'd0, 32'd0, 6'd0, 6'd0); cycle();
    n_cmp++;
    if (a_ra !== 32'd0) begin n_bad++; $display("FAIL t2_x0: ra=%h want 0", a_ra); end
    drive(1'b1, 6'd7, 32'h12345678, 6'd7, 6'd7); cycle();
    n_cmp++;
    if (a_ra !== 32'h12345678 || a_rb !== 32'h12345678) begin
      n_bad++; $display("FAIL t2_dual: ra=%h rb=%h want 12345678", a_ra, a_rb);
    end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 6'd8, 32'hA5A5_0001, 6'd8, 6'd8); cycle();
    drive(1'b1, 6'd8, 32'h5A5A_0002, 6'd8, 6'd8);
    n_cmp++;
    if (a_rb !== 32'hA5A5_0001) begin n_bad++; $display("FAIL b2b_first: rb=%h want a5a50001", a_rb); end
    cycle();
    n_cmp++;
    if (a_ra !== 32'h5A5A_0002) begin n_bad++; $display("FAIL b2b_second: ra=%h want 5a5a0002", a_ra); end
  endtask

  task automatic test_rv32e();
    drive(1'b1, 6'd3, 32'h33, 6'd0, 6'd0); cycle();
    drive(1'b1, 6'h13, 32'hAAAA5555, 6'd0, 6'd0); cycle();
    n_cmp++;
    if (e_err !== 1'b1 || a_err !== 1'b0) begin
      n_bad++; $display("FAIL t3_werr: e=%b i=%b want 1 0", e_err, a_err);
    end
    drive(1'b0, 6'd0, 32'd0, 6'd0, 6'd0); cycle();
    n_cmp++;
    if (e_err !== 1'b0) begin n_bad++; $display("FAIL t3_pulse: err=%b want 0", e_err); end
    drive(1'b0, 6'd0, 32'd0, 6'h13, 6'd3); cycle();
    n_cmp++;
    if (e_err !== 1'b1 || e_ra !== 32'd0) begin
      n_bad++; $display("FAIL t3_rerr: err=%b ra=%h want 1 0", e_err, e_ra);
    end
    n_cmp++;
    if (e_rb !== 32'h33) begin n_bad++; $display("FAIL t3_noalias: x3=%h want 33", e_rb); end
    n_cmp++;
    if (a_ra !== 32'hAAAA5555) begin n_bad++; $display("FAIL t3_rv32i: x19=%h want aaaa5555", a_ra); end
  endtask

  task automatic test_dep();
    drive(1'b1, 6'h26, 32'h8002, 6'd0, 6'd0); cycle();
    n_cmp++;
    if (a_dlo !== 32'h8002) begin n_bad++; $display("FAIL t4_set: dep_lo=%h want 8002", a_dlo); end
    drive(1'b1, 6'h26, 32'h4, 6'd0, 6'h26); cycle();
    n_cmp++;
    if (a_dlo !== 32'h8002 || a_rb !== 32'h8002) begin
      n_bad++; $display("FAIL t4_locked: dep_lo=%h rb=%h want 8002", a_dlo, a_rb);
    end
    drive(1'b1, 6'h27, 32'h4, 6'd0, 6'h27); cycle();
    n_cmp++;
    if (a_dhi !== 32'h4 || a_rb !== 32'h4) begin
      n_bad++; $display("FAIL t4_hi: dep_hi=%h rb=%h want 4", a_dhi, a_rb);
    end
    drive(1'b1, 6'h27, 32'h10, 6'd0, 6'd0); cycle();
    drive(1'b0, 6'd0, 32'd0, 6'd0, 6'd0); repeat (3) cycle();
    n_cmp++;
    if (a_dhi !== 32'h10 || a_dlo !== 32'h8002) begin
      n_bad++; $display("FAIL t4_hold: dep_hi=%h dep_lo=%h want 10 8002", a_dhi, a_dlo);
    end
  endtask

  task automatic test_counters();
    drive(1'b1, 6'h20, 32'hFFFFFFFF, 6'd0, 6'd0); cycle();
    drive(1'b1, 6'h21, 32'h0, 6'd0, 6'd0); cycle();
    drive(1'b0, 6'd0, 32'd0, 6'd0, 6'h21); cycle();
    n_cmp++;
    if (a_rb !== 32'd0) begin n_bad++; $display("FAIL t5_prewrap: mcycleh=%h want 0", a_rb); end
    cycle();
    n_cmp++;
    if (a_rb !== 32'd1) begin n_bad++; $display("FAIL t5_wrap: mcycleh=%h want 1", a_rb); end
    drive(1'b0, 6'd0, 32'd0, 6'd0, 6'h20); cycle();
    n_cmp++;
    if (a_rb !== 32'd1) begin n_bad++; $display("FAIL t5_low: mcycle=%h want 1", a_rb); end
    drive(1'b1, 6'h24, 32'h5, 6'd0, 6'd0); cycle();
    drive(1'b1, 6'h20, 32'h200, 6'd0, 6'd0); cycle();
    drive(1'b1, 6'h22, 32'h100, 6'd0, 6'd0); cycle();
    for (int i = 0; i < 6; i++) begin
      instr_complete = ~instr_complete;
      drive(1'b0, 6'd0, 32'd0, 6'd0, (i % 2 == 0) ? 6'h20 : 6'h22); cycle();
      n_cmp++;
      if (a_rb !== ((i % 2 == 0) ? 32'h200 : 32'h100)) begin
        n_bad++; $display("FAIL t5_inhibit[%0d]: got %h want %h", i, a_rb,
                          (i % 2 == 0) ? 32'h200 : 32'h100);
      end
    end
    instr_complete = 1'b0;
    drive(1'b1, 6'h24, 32'h0, 6'd0, 6'd0); cycle();
    instr_complete = 1'b1;
    drive(1'b0, 6'd0, 32'd0, 6'd0, 6'd0); repeat (3) cycle();
    instr_complete = 1'b0;
    drive(1'b0, 6'd0, 32'd0, 6'd0, 6'h22); cycle();
    n_cmp++;
    if (a_rb !== 32'h103) begin n_bad++; $display("FAIL t5_minstret: got %h want 103", a_rb); end
  endtask

  task automatic test_soft_reset();
    drive(1'b1, 6'h28, 32'h1, 6'd0, 6'h28); cycle();
    n_cmp++;
    if (a_srr !== 1'b1 || a_rb !== 32'd0) begin
      n_bad++; $display("FAIL t6_srr: srr=%b rb=%h want 1 0", a_srr, a_rb);
    end
    drive(1'b0, 6'd0, 32'd0, 6'd0, 6'd0); cycle();
    n_cmp++;
    if (a_srr !== 1'b0 || a_ready !== 1'b1) begin
      n_bad++; $display("FAIL t6_pulse: srr=%b ready=%b want 0 1", a_srr, a_ready);
    end
    drive(1'b1, 6'h30, 32'h55, 6'h30, 6'h30); cycle();
    n_cmp++;
    if (a_rb !== 32'h55 || a_ra !== 32'd0) begin
      n_bad++; $display("FAIL t6_scratch_byp: rb=%h ra=%h want 55 0", a_rb, a_ra);
    end
    drive(1'b0, 6'd0, 32'd0, 6'd0, 6'h30); cycle();
    n_cmp++;
    if (a_rb !== 32'h55) begin n_bad++; $display("FAIL t6_scratch: rb=%h want 55", a_rb); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      reset_n        = ($urandom_range(127) != 0);
      instr_complete = 1'($urandom_range(1));
      rd_wen         = 1'($urandom_range(1));
      rd_waddr       = 6'($urandom_range(63));
      rd_wdata       = $urandom;
      ra_raddr       = ($urandom_range(3) == 0) ? rd_waddr : 6'($urandom_range(63));
      rb_raddr       = ($urandom_range(3) == 0) ? rd_waddr : 6'($urandom_range(63));
      cycle();
      for (int k = 0; k < 2; k++) begin
        logic [31:0] o_ra, o_rb, o_dlo, o_dhi, o_mtvec;
        logic        o_err, o_srr, o_rdy;
        o_ra  = (k == 0) ? a_ra  : e_ra;   o_rb    = (k == 0) ? a_rb    : e_rb;
        o_dlo = (k == 0) ? a_dlo : e_dlo;  o_dhi   = (k == 0) ? a_dhi   : e_dhi;
        o_err = (k == 0) ? a_err : e_err;  o_mtvec = (k == 0) ? a_mtvec : e_mtvec;
        o_srr = (k == 0) ? a_srr : e_srr;  o_rdy   = (k == 0) ? a_ready : e_ready;
        n_cmp++;
        if (o_ra !== x_ra[k] || o_rb !== x_rb[k]) begin
          n_bad++; $display("FAIL rnd_rdata c%0d k%0d: ra=%h rb=%h want %h %h",
                            c, k, o_ra, o_rb, x_ra[k], x_rb[k]);
        end
        n_cmp++;
        if ({o_err, o_srr, o_rdy} !== {x_err[k], x_srr[k], !m_clear[k]}) begin
          n_bad++; $display("FAIL rnd_flags c%0d k%0d: err/srr/rdy=%b want %b", c, k,
                            {o_err, o_srr, o_rdy}, {x_err[k], x_srr[k], !m_clear[k]});
        end
        n_cmp++;
        if ({o_dlo, o_dhi, o_mtvec} !== {m_csr[k][6'h26], m_csr[k][6'h27], m_csr[k][6'h25]}) begin
          n_bad++; $display("FAIL rnd_csr c%0d k%0d: dlo=%h dhi=%h mtvec=%h want %h %h %h",
                            c, k, o_dlo, o_dhi, o_mtvec,
                            m_csr[k][6'h26], m_csr[k][6'h27], m_csr[k][6'h25]);
        end
      end
    end
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    instr_complete = 1'b0;
    drive(1'b0, 6'd0, 32'd0, 6'd0, 6'd0);
    test_reset();
    test_bypass();
    test_back_to_back();
    test_rv32e();
    test_dep();
    test_counters();
    test_soft_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
